// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU.
// Fetch entries carry an instruction word and its PC.
package tiny_cpu_pkg;

  localparam int XLEN       = 32;
  localparam int DEF_ADDR_W = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {data, pc} entries.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import tiny_cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are masked while empty
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests,
// prefetch buffering and redirect handling.
module fetch_unit
  import tiny_cpu_pkg::*;
#(
  parameter int          ADDR_W   = tiny_cpu_pkg::DEF_ADDR_W,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              pop;
  logic              issue;
  logic [CW:0]       occ;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              unused_full;
  logic              unused_head;
  fetch_entry_t      head;
  fetch_entry_t      wentry;

  assign pop = instr_valid && instr_ready;

  // Slots committed after this cycle: buffered + in flight - leaving
  always_comb begin
    occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue = RST_N && !redirect_valid
            && (occ < (CW+1)'(DEPTH));
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  assign wentry = '{data: XLEN'(imem_rdata),
                    pc:   XLEN'(inflight_pc)};

  // PC and in-flight tracking; redirect overrides issue
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (inflight),
    .wdata (wentry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count),
    .full  (unused_full),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = head.data[DATA_W-1:0];
  assign instr_pc    = head.pc[ADDR_W-1:0];
  assign unused_head = ^head.pc[XLEN-1:ADDR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a
// one-cycle-latency instruction memory model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [3:0]  instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int hs_cnt   = 0;

  fetch_unit #(
    .ADDR_W   (4),
    .DATA_W   (32),
    .DEPTH    (2),
    .RESET_PC (0)
  ) dut (
    .CLK            (CLK),
    .RST_N          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 CLK = ~CLK;

  // memory: data for a request appears the following cycle
  always @(posedge CLK) begin
    if (imem_req) imem_rdata <= 32'hA000_0000 + {28'h0, imem_addr};
    else          imem_rdata <= 32'hBAD0_0BAD;
  end

  // handshake counter seen by the core
  always @(posedge CLK) begin
    if (rst_n && instr_valid && instr_ready) hs_cnt++;
  end

  // the FIFO must never be pushed while full without a pop
  always @(posedge CLK) begin
    if (rst_n && dut.u_fifo.push && !dut.u_fifo.flush) begin
      chk_cnt++;
      if (dut.u_fifo.full && !dut.u_fifo.pop)
        $display("FAIL overflow: push into full fifo at %0t", $time);
      else pass_cnt++;
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_head(string nm, logic [3:0] pc);
    chk_cnt++;
    if (instr_valid !== 1'b1 || instr_pc !== pc
        || instr_data !== (32'hA000_0000 + {28'h0, pc}))
      $display("FAIL %s: got v=%b pc=%0d d=%h exp v=1 pc=%0d d=%h",
               nm, instr_valid, instr_pc, instr_data,
               pc, 32'hA000_0000 + {28'h0, pc});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 4'd0;
    tick();
    #1;
    chk_cnt++;
    if (imem_req !== 1'b0)
      $display("FAIL rst_req: got %b exp 0", imem_req);
    else pass_cnt++;
    chk_cnt++;
    if (imem_addr !== 4'd0)
      $display("FAIL rst_addr: got %0d exp 0", imem_addr);
    else pass_cnt++;
    chk_cnt++;
    if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 4'd0)
      $display("FAIL rst_out: got v=%b d=%h pc=%0d exp 0/0/0",
               instr_valid, instr_data, instr_pc);
    else pass_cnt++;
  endtask

  task automatic test_free_run();
    do_reset();
    instr_ready = 1'b1;
    #1;
    chk_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 4'd0)
      $display("FAIL fr_first_req: got r=%b a=%0d exp 1/0",
               imem_req, imem_addr);
    else pass_cnt++;
    tick(); #1;
    chk_cnt++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 4'd1)
      $display("FAIL fr_cyc1: got v=%b r=%b a=%0d exp 0/1/1",
               instr_valid, imem_req, imem_addr);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      chk_head("fr_stream", 4'(k));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick();
    for (int c = 2; c < 7; c++) begin
      tick(); #1;
      chk_head("bp_hold", 4'd0);
      chk_cnt++;
      if (imem_req !== 1'b0)
        $display("FAIL bp_req_full: cyc %0d got %b exp 0", c, imem_req);
      else pass_cnt++;
    end
    tick();
    instr_ready = 1'b1;
    #1;
    chk_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 4'd2)
      $display("FAIL bp_resume_req: got r=%b a=%0d exp 1/2",
               imem_req, imem_addr);
    else pass_cnt++;
    chk_head("bp_resume", 4'd0);
    for (int k = 1; k < 4; k++) begin
      tick(); #1;
      chk_head("bp_order", 4'(k));
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 4'd9;
    #1;
    chk_cnt++;
    if (imem_req !== 1'b0)
      $display("FAIL rd_req_in_redirect: got %b exp 0", imem_req);
    else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk_cnt++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 4'd9)
      $display("FAIL rd_k1: got v=%b r=%b a=%0d exp 0/1/9",
               instr_valid, imem_req, imem_addr);
    else pass_cnt++;
    tick(); #1;
    chk_cnt++;
    if (instr_valid !== 1'b0 || imem_addr !== 4'd10)
      $display("FAIL rd_k2: got v=%b a=%0d exp 0/10",
               instr_valid, imem_addr);
    else pass_cnt++;
    tick(); #1;
    chk_head("rd_first", 4'd9);
    tick(); #1;
    chk_head("rd_second", 4'd10);
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 4'd14;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 4'd14)
      $display("FAIL wr_req: got r=%b a=%0d exp 1/14",
               imem_req, imem_addr);
    else pass_cnt++;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk_head("wr_seq", 4'(14 + k));
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 4'd5;
    hs_cnt = 0;
    #1;
    chk_head("rp_head", 4'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_cnt++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 4'd5)
      $display("FAIL rp_k1: got v=%b r=%b a=%0d exp 0/1/5",
               instr_valid, imem_req, imem_addr);
    else pass_cnt++;
    tick(); #1;
    chk_cnt++;
    if (hs_cnt !== 1)
      $display("FAIL rp_handshakes: got %0d exp 1", hs_cnt);
    else pass_cnt++;
    tick(); #1;
    chk_head("rp_restart", 4'd5);
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    @(posedge CLK);
    #3;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (imem_req !== 1'b0 || imem_addr !== 4'd0 || instr_valid !== 1'b0
        || instr_data !== 32'h0 || instr_pc !== 4'd0)
      $display("FAIL rm_async: got r=%b a=%0d v=%b d=%h pc=%0d exp all 0",
               imem_req, imem_addr, instr_valid, instr_data, instr_pc);
    else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 4'd0)
      $display("FAIL rm_restart_req: got r=%b a=%0d exp 1/0",
               imem_req, imem_addr);
    else pass_cnt++;
    tick();
    tick(); #1;
    chk_head("rm_restart", 4'd0);
    tick(); #1;
    chk_head("rm_next", 4'd1);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_redirect_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
